// File: rtl/module_keypad_scanner_if.sv
// Keypad scanner bundle: row returns from the matrix, column strobes and key event outputs.
// The master side is the scanner itself; the slave side is the keypad/consumer.
interface module_keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, output key_code, output key_valid, output key_held);
    modport slave  (output row, input col, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, samples synchronized rows,
// and debounces whole sweeps so a single key yields exactly one press event.
module module_keypad_scanner #(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    module_keypad_scanner_if.master kp
);
    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    logic [3:0]        row_meta_reg, row_sync_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [1:0]        col_idx_reg;
    logic [3:0]        col_reg;
    logic              slot_end, sweep_end;
    logic [15:0]       pressed;
    logic [1:0]        ones;
    logic [3:0]        scan_code;
    logic              is_none, is_single;

    state_t            state_reg, state_next;
    logic [3:0]        cand_reg, cand_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_plus;
    logic [3:0]        key_code_reg, key_code_next;
    logic              key_valid_reg, key_valid_next;
    logic              key_held_reg, key_held_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
        end else begin
            row_meta_reg <= kp.row;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign slot_end  = (tick_reg == TICK_LAST);
    assign sweep_end = slot_end && (col_idx_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg    <= '0;
            col_idx_reg <= 2'd0;
            col_reg     <= 4'b1110;
        end else if (slot_end) begin
            tick_reg    <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_reg     <= {col_reg[2:0], col_reg[3]};
        end else begin
            tick_reg    <= tick_reg + TICK_W'(1);
        end
    end

    // Columns 0..2 are latched at their slot end; column 3 is read live, since its
    // slot end is the sweep end where the whole matrix is classified.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            if (gi < 3) begin : g_reg
                logic [3:0] smp_reg;
                always_ff @(posedge clk) begin
                    if (rst)
                        smp_reg <= 4'b0000;
                    else if (slot_end && (col_idx_reg == 2'(gi)))
                        smp_reg <= ~row_sync_reg;
                end
                assign {pressed[12+gi], pressed[8+gi], pressed[4+gi], pressed[gi]} = smp_reg;
            end else begin : g_live
                assign {pressed[12+gi], pressed[8+gi], pressed[4+gi], pressed[gi]} = ~row_sync_reg;
            end
        end
    endgenerate

    always_comb begin
        ones      = 2'd0;
        scan_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                scan_code = 4'(i);
                if (ones != 2'd2)
                    ones = ones + 2'd1;
            end
        end
    end

    assign is_none   = (ones == 2'd0);
    assign is_single = (ones == 2'd1);
    assign cnt_plus  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cand_reg      <= 4'd0;
            cnt_reg       <= '0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;
        if (sweep_end) begin
            case (state_reg)
                IDLE: begin
                    if (is_single) begin
                        cand_next = scan_code;
                        if (ONE_SCAN) begin
                            state_next     = PRESSED;
                            key_code_next  = scan_code;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            state_next = PRESS_DB;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                PRESS_DB: begin
                    if (is_single && (scan_code == cand_reg)) begin
                        if (cnt_plus == CNT_MAX) begin
                            state_next     = PRESSED;
                            key_code_next  = scan_code;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = cnt_plus;
                        end
                    end else if (is_single) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                PRESSED: begin
                    // Further keys while held are deliberately ignored until a clean release.
                    if (is_none) begin
                        if (ONE_SCAN) begin
                            state_next    = IDLE;
                            key_held_next = 1'b0;
                            cnt_next      = '0;
                        end else begin
                            state_next = RELEASE_DB;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (is_none) begin
                        if (cnt_plus == CNT_MAX) begin
                            state_next    = IDLE;
                            key_held_next = 1'b0;
                            cnt_next      = '0;
                        end else begin
                            cnt_next = cnt_plus;
                        end
                    end else begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign kp.col       = col_reg;
    assign kp.key_code  = key_code_reg;
    assign kp.key_valid = key_valid_reg;
    assign kp.key_held  = key_held_reg;
endmodule

// File: doc/module_keypad_scanner.md
MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_TICKS, default 50000: clock cycles each column is driven (minimum 4).
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full sweeps required to accept a press or a release (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: column strobes, active-low, registered.
REQ-007 The block SHALL have port key_code, output, 4 bits: last accepted key, equal to row_index*4 + col_index.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a press is accepted.
REQ-009 The block SHALL have port key_held, output, 1 bit: level, high from acceptance of a press until acceptance of its release.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Exactly one col bit SHALL be low at any time after reset, rotating col index 0->1->2->3->0, each held SCAN_TICKS cycles; a sweep is 4*SCAN_TICKS cycles.
REQ-012 Synchronized rows SHALL be sampled on the last cycle of each column slot, which allows settling time plus synchronizer delay.
REQ-013 At each sweep end the block SHALL classify the 16 samples as NONE (0 pressed), SINGLE(code) (exactly 1 pressed), or MULTI (2 or more pressed).
REQ-014 The FSM SHALL have four states: IDLE, PRESS_DB, PRESSED, and RELEASE_DB; all transitions SHALL occur only at sweep end.
REQ-015 In IDLE, SINGLE(c) SHALL store candidate c, set the stable count to 1, and go to PRESS_DB; NONE and MULTI SHALL remain in IDLE.
REQ-016 In PRESS_DB, SINGLE(same c) SHALL increment the count; SINGLE(different c) SHALL reload the candidate with count 1; NONE or MULTI SHALL return to IDLE.
REQ-017 In PRESS_DB, when the count reaches DEBOUNCE_SCANS the block SHALL go to PRESSED, load key_code=c, pulse key_valid for exactly one cycle (the cycle after sweep end), and set key_held=1.
REQ-018 In PRESSED, NONE SHALL go to RELEASE_DB with count 1; SINGLE(any) and MULTI SHALL stay in PRESSED, so extra keys never generate a second event.
REQ-019 In RELEASE_DB, NONE SHALL increment the count; any pressed key SHALL return to PRESSED; at count DEBOUNCE_SCANS the block SHALL go to IDLE and clear key_held.
REQ-020 When DEBOUNCE_SCANS=1, acceptance SHALL occur at the first qualifying sweep end (IDLE->PRESSED, PRESSED->IDLE directly).
REQ-021 The stable counter SHALL saturate at DEBOUNCE_SCANS, and the cycle counter SHALL wrap at SCAN_TICKS-1 with no overflow.
REQ-022 key_code SHALL hold its value until the next accepted press; it SHALL NOT change on release.

Reset
REQ-023 While rst=1, the block SHALL hold col=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters=0, and synchronizer flops=4'b1111.
REQ-024 A reset asserted mid-sweep or while PRESSED SHALL abort immediately with no key_valid pulse; scanning SHALL restart at column 0 the cycle after rst falls.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=3, sweep=16 cycles; keypad model pulls row r low when col c is low and key (r,c) is pressed)
REQ-025 The bench SHALL cover: reset, no keys -> col rotates 1110,1101,1011,0111 every 4 cycles; key_valid is never asserted.
REQ-026 The bench SHALL cover: key (2,1) held steady -> exactly one key_valid pulse at the end of the 3rd full sweep, with key_code=9 and key_held=1; key_held=0 three sweeps after release.
REQ-027 The bench SHALL cover: key (0,3) bouncing (toggling every 5 cycles for 2 sweeps) then stable -> no pulse during bounce; one pulse with key_code=3 after 3 stable sweeps.
REQ-028 The bench SHALL cover: keys (1,0) and (3,3) pressed together from IDLE -> no pulse; after (3,3) is released and (1,0) remains, one pulse with key_code=4.
REQ-029 The bench SHALL cover: while PRESSED with key 5, release for 1 sweep then re-press 5 -> key_held stays 1 and no second pulse.
REQ-030 The bench SHALL cover: rst pulsed for 1 cycle during PRESS_DB of key 7 -> no pulse, col=1110, and re-acceptance of key 7 after a full 3 sweeps.
